// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache.
//   - cache_state_t : controller states (IDLE, FILL, WRITE)
//   - *_DEF         : default geometry, used as parameter defaults by the top
//   - TAG_W, BLOCK_W, SETS : derived sizes for the default geometry
//   - addr_tag / addr_set / addr_word : address field extraction for any geometry
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int ADDRESS_WIDTH_DEF = 30;
  localparam int SET_BITS_DEF      = 5;
  localparam int BLOCK_SIZE_DEF    = 3;
  localparam int WAYS_DEF          = 2;

  localparam int TAG_W   = ADDRESS_WIDTH_DEF - SET_BITS_DEF - BLOCK_SIZE_DEF;
  localparam int BLOCK_W = DATA_WIDTH_DEF << BLOCK_SIZE_DEF;
  localparam int SETS    = 1 << SET_BITS_DEF;

  // Generic bit-field extract; callers cast the result to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lo, input int w);
    return (a >> lo) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int set_bits, input int block_size);
    return a >> (set_bits + block_size);
  endfunction

  function automatic logic [63:0] addr_set(input logic [63:0] a, input int set_bits, input int block_size);
    return addr_field(a, block_size, set_bits);
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] a, input int block_size);
    return addr_field(a, 0, block_size);
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set replacement state for the set-associative cache.
//   set       : set being looked up / touched
//   touch_way : way to mark most-recently used
//   touch_en  : apply touch_way to set at the next edge
//   valid     : valid bits of the ways in set
//   victim    : lowest-index invalid way, else the pseudo-LRU way of set
// WAYS=1 keeps no state, WAYS=2 one bit per set, WAYS=4 a 3-bit tree per set.
module cache_plru
  import cache_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int WAYS     = WAYS_DEF,
  parameter int WAY_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] set,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                touch_en,
  input  logic [WAYS-1:0]     valid,
  output logic [WAY_BITS-1:0] victim
);

  localparam int NUM_SETS = 1 << SET_BITS;

  logic [WAY_BITS-1:0] lru_way;

  if (WAYS == 1) begin : g_direct
    assign lru_way = '0;
  end else if (WAYS == 2) begin : g_two
    // Bit holds the least-recently used way of the set.
    logic [NUM_SETS-1:0] lru_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lru_q <= '0;
      end else if (touch_en) begin
        lru_q[set] <= ~touch_way[0];
      end
    end

    assign lru_way = lru_q[set];
  end else begin : g_four
    // [0] points at the colder pair, [1] the colder of ways 0/1, [2] of ways 2/3.
    logic [NUM_SETS-1:0][2:0] tree_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tree_q <= '0;
      end else if (touch_en) begin
        tree_q[set][0] <= ~touch_way[1];
        if (touch_way[1]) tree_q[set][2] <= ~touch_way[0];
        else              tree_q[set][1] <= ~touch_way[0];
      end
    end

    assign lru_way = tree_q[set][0] ? {1'b1, tree_q[set][2]} : {1'b0, tree_q[set][1]};
  end

  // Empty ways are always filled before anything is evicted.
  always_comb begin
    victim = lru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative, write-through, write-allocate data cache.
//   core side : req, we, addr, wdata -> rdata, stall (hold request while stall=1)
//   mem side  : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata (block), mem_ack (1-cycle pulse)
// Optional macro CACHE_PERF_EN adds hit_count / miss_count outputs.
// Loads that hit return data combinationally; misses fill a block (FILL), every
// store ends with a single-word write-through (WRITE).
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int SET_BITS      = SET_BITS_DEF,
  parameter int BLOCK_SIZE    = BLOCK_SIZE_DEF,
  parameter int WAYS          = WAYS_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req,
  input  logic                                we,
  input  logic [ADDRESS_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]               wdata,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                stall,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDRESS_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [(DATA_WIDTH<<BLOCK_SIZE)-1:0] mem_rdata,
  input  logic                                mem_ack
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0]                         hit_count,
  output logic [31:0]                         miss_count
`endif
);

  localparam int TAG_BITS = ADDRESS_WIDTH - SET_BITS - BLOCK_SIZE;
  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int BLK_BITS = DATA_WIDTH << BLOCK_SIZE;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_BITS-1:0]   a_tag;
  logic [SET_BITS-1:0]   a_set;
  logic [BLOCK_SIZE-1:0] a_word;
  logic [31:0]           word_lsb;

  assign a_tag    = TAG_BITS'(addr_tag(64'(addr), SET_BITS, BLOCK_SIZE));
  assign a_set    = SET_BITS'(addr_set(64'(addr), SET_BITS, BLOCK_SIZE));
  assign a_word   = BLOCK_SIZE'(addr_word(64'(addr), BLOCK_SIZE));
  assign word_lsb = 32'(a_word) * 32'(DATA_WIDTH);

  logic [NUM_SETS-1:0][WAYS-1:0] valid_q;
  logic [TAG_BITS-1:0]           tag_q  [NUM_SETS][WAYS];
  logic [BLK_BITS-1:0]           data_q [NUM_SETS][WAYS];

  cache_state_t        state_q, state_d;
  logic                retry_q;   // first IDLE cycle after FILL/WRITE: request already served
  logic                hit;
  logic [WAY_BITS-1:0] hit_way, victim, touch_way;
  logic                touch_en, fill_en, merge_en;
  logic [BLK_BITS-1:0] hit_block, fill_block, merged_block;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[a_set][w] && tag_q[a_set][WAY_BITS'(w)] == a_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  assign hit_block = data_q[a_set][hit_way];
  assign rdata     = hit_block[word_lsb +: DATA_WIDTH];

  // Store data is merged both into a hit line and into an incoming fill block.
  always_comb begin
    merged_block = hit_block;
    merged_block[word_lsb +: DATA_WIDTH] = wdata;
    fill_block = mem_rdata;
    if (we) fill_block[word_lsb +: DATA_WIDTH] = wdata;
  end

  cache_plru #(
    .SET_BITS (SET_BITS),
    .WAYS     (WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .set       (a_set),
    .touch_way (touch_way),
    .touch_en  (touch_en),
    .valid     (valid_q[a_set]),
    .victim    (victim)
  );

  always_comb begin
    state_d   = state_q;
    touch_en  = 1'b0;
    touch_way = hit_way;
    fill_en   = 1'b0;
    merge_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            touch_en = 1'b1;
            // A store retried after its WRITE is complete and is not replayed.
            if (we && !retry_q) begin
              merge_en = 1'b1;
              state_d  = WRITE;
            end
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim;
          state_d   = we ? WRITE : IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q != IDLE) || (req && (!hit || (we && !retry_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retry_q   <= 1'b0;
      valid_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= (state_q != IDLE) && (state_d == IDLE);
      if (fill_en) valid_q[a_set][victim] <= 1'b1;
      // Memory outputs are registered and loaded on entry to each state.
      if (state_d == FILL && state_q != FILL) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= {addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
      end else if (state_d == WRITE && state_q != WRITE) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= wdata;
      end else if (state_d == IDLE) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays have no reset; valid_q alone decides whether
  // their contents mean anything, which keeps them mappable to RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[a_set][victim] <= fill_block;
      tag_q[a_set][victim]  <= a_tag;
    end else if (merge_en) begin
      data_q[a_set][hit_way] <= merged_block;
    end
  end

`ifdef CACHE_PERF_EN
  // Judged once, at the first IDLE presentation of each access.
  logic fresh;
  assign fresh = (state_q == IDLE) && req && !retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (fresh) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache (default geometry: 32-bit words,
// 30-bit word address, 32 sets, 8-word blocks, 2 ways).
// A reference model (per-set true-LRU tag lists plus a flat word memory)
// predicts memory transactions and load data; a memory responder and a
// load monitor pop those expectations as the DUT produces them.
module tb_set_assoc_cache;

  localparam int WAYS = 2;

  typedef struct {
    bit          we;
    logic [29:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [29:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [29:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef CACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int total = 0;
  int bad   = 0;

  mem_txn_t    exp_mem_q[$];
  logic [31:0] exp_load_q[$];
  int unsigned lru_q[32][$];              // per set: tags, most recent first
  logic [31:0] ref_mem [int unsigned];    // model's view of memory
  logic [31:0] bus_mem [int unsigned];    // responder's memory
  int          force_lat = -1;
  bit          stray_ack = 1'b0;

  set_assoc_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] a);
    if (bus_mem.exists(int'(a))) return bus_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 32; s++) lru_q[s].delete();
  endtask

  // tag = addr >> 8, set = addr[7:3]; a store is a write-through plus allocate.
  task automatic model_access(input bit w, input logic [29:0] a, input logic [31:0] d, output bit hit);
    int unsigned s   = (int'(a) >> 3) & 31;
    int unsigned tg  = int'(a) >> 8;
    int          idx = -1;
    mem_txn_t    t;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == tg) idx = i;
    hit = (idx >= 0);
    if (hit) lru_q[s].delete(idx);
    lru_q[s].push_front(tg);
    if (lru_q[s].size() > WAYS) void'(lru_q[s].pop_back());
    if (!hit) begin
      t.we = 1'b0; t.addr = a & ~30'd7; t.data = 32'd0;
      exp_mem_q.push_back(t);
    end
    if (w) begin
      t.we = 1'b1; t.addr = a; t.data = d;
      exp_mem_q.push_back(t);
      ref_mem[int'(a)] = d;
    end else begin
      exp_load_q.push_back(ref_rd(a));
    end
  endtask

  task automatic do_access(input bit w, input logic [29:0] a, input logic [31:0] d, output int cycles);
    bit exp_hit;
    model_access(w, a, d, exp_hit);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    #2;
    check($sformatf("first_stall %0h", a), 64'(stall), 64'(!(exp_hit && !w)));
    cycles = 0;
    while (stall && cycles < 1000) begin
      @(negedge clk); #2;
      cycles++;
    end
    if (cycles >= 1000) check("access_timeout", 64'(stall), 64'd0);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Load monitor: a completed load is one sampled cycle of req & !we & !stall.
  initial forever begin
    @(negedge clk); #2;
    if (rst_n === 1'b1 && req && !we && !stall) begin
      if (exp_load_q.size() == 0) begin
        total++; bad++;
        $display("FAIL load_unexpected: got load %0h want none", addr);
      end else begin
        check($sformatf("rdata %0h", addr), 64'(rdata), 64'(exp_load_q.pop_front()));
      end
    end
  end

  // Memory responder and transaction monitor.
  initial begin : responder
    mem_txn_t e;
    bit       we_s, held, aborted;
    logic [29:0] addr_s;
    logic [31:0] data_s;
    int       lat;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      if (rst_n === 1'b1 && mem_req) begin
        we_s = mem_we; addr_s = mem_addr; data_s = mem_wdata;
        if (exp_mem_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got we=%0d addr=%0h want none", we_s, addr_s);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_we", 64'(we_s), 64'(e.we));
          check("mem_addr", 64'(addr_s), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(data_s), 64'(e.data));
        end
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
        held = 1'b1; aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk); #2;
          if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
          if (!mem_req || mem_we !== we_s || mem_addr !== addr_s || stall !== 1'b1) held = 1'b0;
        end
        if (!aborted) begin
          check("mem_hold", 64'(held), 64'd1);
          @(negedge clk);
          if (we_s) bus_mem[int'(addr_s)] = data_s;
          else for (int i = 0; i < 8; i++) mem_rdata[i*32 +: 32] = bus_rd(addr_s + 30'(i));
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end
      end else if (stray_ack) begin
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        stray_ack = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int          cyc;
    mem_txn_t    t;
    logic [29:0] a;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Cold read with a 5-cycle memory, then the same address hits.
    force_lat = 5;
    do_access(1'b0, 30'h100, 32'd0, cyc);
    force_lat = -1;
    do_access(1'b0, 30'h100, 32'd0, cyc);
    check("hit_no_stall_cycles", 64'(cyc), 64'd0);

    // Three tags in set 5: A, B, A, C (evicts B), A, B.
    do_access(1'b0, 30'h1028, 32'd0, cyc);
    do_access(1'b0, 30'h2028, 32'd0, cyc);
    do_access(1'b0, 30'h1028, 32'd0, cyc);
    do_access(1'b0, 30'h3028, 32'd0, cyc);
    do_access(1'b0, 30'h1028, 32'd0, cyc);
    do_access(1'b0, 30'h2028, 32'd0, cyc);

    // Write miss allocates, then a read of the stored word hits.
    do_access(1'b1, 30'h204, 32'hDEAD_BEEF, cyc);
    do_access(1'b0, 30'h204, 32'd0, cyc);
    do_access(1'b1, 30'h205, 32'hCAFE_F00D, cyc);
    do_access(1'b0, 30'h205, 32'd0, cyc);

    // Reset in the middle of a fill abandons it.
    force_lat = 1000;
    t.we = 1'b0; t.addr = 30'h300; t.data = 32'd0;
    exp_mem_q.push_back(t);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 30'h300;
    repeat (8) @(negedge clk);
    #2;
    check("midfill_mem_req", 64'(mem_req), 64'd1);
    @(negedge clk); rst_n = 1'b0; req = 1'b0;
    #1;
    check("midfill_rst_mem_req", 64'(mem_req), 64'd0);
    check("midfill_rst_stall", 64'(stall), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    force_lat = -1;
    do_access(1'b0, 30'h300, 32'd0, cyc);
    do_access(1'b0, 30'h100, 32'd0, cyc);

    // Slow memory: stall and the request are held for the whole wait.
    force_lat = 100;
    do_access(1'b0, 30'h400, 32'd0, cyc);
    force_lat = -1;
    check("long_stall_held", 64'(cyc >= 100), 64'd1);

    // Stray mem_ack while idle changes nothing.
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check("stray_stall", 64'(stall), 64'd0);
    check("stray_mem_req", 64'(mem_req), 64'd0);
    do_access(1'b0, 30'h400, 32'd0, cyc);

    // Random mix over 4 tags x 4 sets x 8 words, about a third stores.
    for (int n = 0; n < 150; n++) begin
      a = 30'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7));
      do_access($urandom_range(0, 2) == 0, a, $urandom, cyc);
    end

`ifdef CACHE_PERF_EN
    @(negedge clk); rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 30'h100, 32'd0, cyc);
    do_access(1'b0, 30'h108, 32'd0, cyc);
    do_access(1'b0, 30'h110, 32'd0, cyc);
    do_access(1'b0, 30'h100, 32'd0, cyc);
    do_access(1'b0, 30'h108, 32'd0, cyc);
    do_access(1'b0, 30'h110, 32'd0, cyc);
    do_access(1'b0, 30'h101, 32'd0, cyc);
    do_access(1'b0, 30'h109, 32'd0, cyc);
    #2;
    check("perf_miss_count", 64'(miss_count), 64'd3);
    check("perf_hit_count", 64'(hit_count), 64'd5);
`endif

    repeat (20) @(negedge clk);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
    check("load_queue_drained", 64'(exp_load_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
